// File: rtl/fb_reader.sv
// Frame-buffer pixel reader for the MADAM line-pair-interleaved layout.
// Optional one-entry word cache enabled by defining FB_READER_CACHE_EN.

package fb_reader_pkg;
    parameter int unsigned NUM_REGS    = 8;
    parameter int unsigned FBTARGET_ID = 4;

    typedef struct packed {
        logic [NUM_REGS-1:0][31:0] regs;
        logic [31:0]               wmod;
    } mcore_t;
endpackage

interface mem_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rsp_valid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rsp_valid, rdata);
endinterface

module fb_reader
    import fb_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned PIXEL_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    mem_if.master                  memory,
    input  mcore_t                 mcore,
    input  logic [15:0]            x,
    input  logic [15:0]            y,
    input  logic                   req,
    output logic                   resp,
    output logic [PIXEL_WIDTH-1:0] pixel,
    output logic                   busy,
    input  logic                   invalidate
);

    typedef enum logic [2:0] {StIdle, StCalc, StMemReq, StMemRsp, StDone} state_e;

    state_e                  state_q, state_d;
    logic [15:0]             x_q, y_q, wmod_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    half_q, half_d;
    logic [PIXEL_WIDTH-1:0]  pixel_q, pixel_d;
    logic [ADDR_WIDTH-1:0]   woff, addr_calc;
    logic                    accept, fill, mem_req;
    logic                    cache_hit;
    logic [DATA_WIDTH-1:0]   cache_word;

    // Even lines live in the upper half of a word, odd lines in the lower half.
    function automatic logic [PIXEL_WIDTH-1:0] pick(input logic [DATA_WIDTH-1:0] w,
                                                     input logic odd);
        return odd ? w[PIXEL_WIDTH-1:0] : w[DATA_WIDTH-1 -: PIXEL_WIDTH];
    endfunction

    assign woff      = ADDR_WIDTH'(y_q[15:1]) * ADDR_WIDTH'(wmod_q) + ADDR_WIDTH'(x_q);
    assign addr_calc = base_q + (woff << 2);
    assign accept    = (state_q == StIdle) && req;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        half_d  = half_q;
        pixel_d = pixel_q;
        fill    = 1'b0;
        mem_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) state_d = StCalc;
            end
            StCalc: begin
                addr_d = addr_calc;
                half_d = y_q[0];
                if (cache_hit) begin
                    pixel_d = pick(cache_word, y_q[0]);
                    state_d = StDone;
                end else begin
                    state_d = StMemReq;
                end
            end
            StMemReq: begin
                mem_req = 1'b1;
                // rsp_valid without gnt belongs to nobody and is dropped.
                if (memory.gnt) begin
                    if (memory.rsp_valid) begin
                        pixel_d = pick(memory.rdata, half_q);
                        fill    = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StMemRsp;
                    end
                end
            end
            StMemRsp: begin
                if (memory.rsp_valid) begin
                    pixel_d = pick(memory.rdata, half_q);
                    fill    = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            wmod_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            half_q  <= 1'b0;
            pixel_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            half_q  <= half_d;
            pixel_q <= pixel_d;
            if (accept) begin
                x_q    <= x;
                y_q    <= y;
                wmod_q <= mcore.wmod[15:0];
                base_q <= mcore.regs[FBTARGET_ID][ADDR_WIDTH-1:0];
            end
        end
    end

`ifdef FB_READER_CACHE_EN
    logic                  cache_valid_q;
    logic [ADDR_WIDTH-1:0] cache_addr_q;
    logic [DATA_WIDTH-1:0] cache_data_q;

    // An invalidate racing a fill wins, so the fresh word is not trusted.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
        end else if (fill) begin
            cache_valid_q <= !invalidate;
            cache_addr_q  <= addr_q;
            cache_data_q  <= memory.rdata;
        end else if (invalidate) begin
            cache_valid_q <= 1'b0;
        end
    end

    assign cache_hit  = cache_valid_q && (cache_addr_q == addr_calc);
    assign cache_word = cache_data_q;
`else
    logic unused_invalidate;
    assign unused_invalidate = invalidate ^ fill;
    assign cache_hit         = 1'b0;
    assign cache_word        = '0;
`endif

    logic unused_mcore;
    assign unused_mcore = ^mcore;

    assign memory.req   = mem_req;
    assign memory.we    = 1'b0;
    assign memory.be    = '1;
    assign memory.wdata = '0;
    assign memory.addr  = addr_q;

    assign resp  = (state_q == StDone);
    assign busy  = (state_q != StIdle);
    assign pixel = pixel_q;

endmodule
